// File: rtl/ctrl_multiciclo_pkg.sv
// Shared encodings for the multicycle main control unit:
// state codes, opcodes, select codes and the control word.
package ctrl_multiciclo_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13
  } estado_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [1:0] ALUOP_LW_SW_ADDI    = 2'b00;
  localparam logic [1:0] ALUOP_BEQ_BNE       = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE         = 2'b10;
  localparam logic [1:0] ALUOP_ANDI_ORI_XORI = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR = 2'b01;
  localparam logic [1:0] MEMTOREG_PC  = 2'b10;

  localparam logic [1:0] ALUSRCB_B   = 2'b00;
  localparam logic [1:0] ALUSRCB_4   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM = 2'b10;
  localparam logic [1:0] ALUSRCB_BR  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       pcwritecondne;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       extop;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_logic_imm(
    input logic [5:0] op
  );
    return (op == OP_ANDI) || (op == OP_ORI)
        || (op == OP_XORI);
  endfunction

  function automatic logic is_legal(
    input logic [5:0] op
  );
    return (op == OP_RTYPE) || (op == OP_J)
        || (op == OP_JAL) || (op == OP_BEQ)
        || (op == OP_BNE) || (op == OP_ADDI)
        || is_logic_imm(op)
        || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/ctrl_decod_saida.sv
// State + opcode to control-word decoder (Moore outputs).
// While rst is high it presents FETCH selects with writes held off.
module ctrl_decod_saida
  import ctrl_multiciclo_pkg::*;
(
  input  logic       rst,
  input  estado_t    estado,
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  estado_t st;
  logic    logi;

  always_comb begin
    st   = rst ? S_FETCH : estado;
    logi = is_logic_imm(opcode);
    ctrl = '0;
    ctrl.extop = 1'b1;
    unique case (st)
      S_FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
        ctrl.alusrcb = ALUSRCB_4;
        ctrl.aluop   = ALUOP_LW_SW_ADDI;
      end
      S_DECODE: begin
        ctrl.alusrcb    = ALUSRCB_BR;
        ctrl.aluop      = ALUOP_LW_SW_ADDI;
        ctrl.illegal_op = !is_legal(opcode);
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.aluop   = ALUOP_LW_SW_ADDI;
      end
      S_MEMRD: begin
        ctrl.iord    = 1'b1;
        ctrl.memread = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.memtoreg   = MEMTOREG_MDR;
        ctrl.regdst     = REGDST_RT;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord       = 1'b1;
        ctrl.memwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_B;
        ctrl.aluop   = ALUOP_RTYPE;
      end
      S_ALUWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.regdst     = REGDST_RD;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca       = 1'b1;
        ctrl.aluop         = ALUOP_BEQ_BNE;
        ctrl.pcsource      = PCSRC_ALUOUT;
        ctrl.pcwritecond   = (opcode == OP_BEQ);
        ctrl.pcwritecondne = (opcode == OP_BNE);
        ctrl.instr_done    = 1'b1;
      end
      S_IEXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = ALUSRCB_IMM;
        ctrl.extop   = !logi;
        ctrl.aluop   = logi ? ALUOP_ANDI_ORI_XORI
                            : ALUOP_LW_SW_ADDI;
      end
      S_IWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.regdst     = REGDST_RT;
        ctrl.extop      = !logi;
        ctrl.aluop      = logi ? ALUOP_ANDI_ORI_XORI
                               : ALUOP_LW_SW_ADDI;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcwrite    = 1'b1;
        ctrl.pcsource   = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      // MemtoReg=PC picks up PC+4 latched before the jump lands
      S_JAL: begin
        ctrl.pcwrite    = 1'b1;
        ctrl.pcsource   = PCSRC_JUMP;
        ctrl.regwrite   = 1'b1;
        ctrl.regdst     = REGDST_RA;
        ctrl.memtoreg   = MEMTOREG_PC;
        ctrl.instr_done = 1'b1;
      end
      S_JR: begin
        ctrl.pcwrite    = 1'b1;
        ctrl.pcsource   = PCSRC_REGA;
        ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      ctrl.pcwrite       = 1'b0;
      ctrl.pcwritecond   = 1'b0;
      ctrl.pcwritecondne = 1'b0;
      ctrl.irwrite       = 1'b0;
      ctrl.regwrite      = 1'b0;
      ctrl.memwrite      = 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_multiciclo.sv
// Multicycle main control FSM: state register and next-state
// logic; control outputs come from ctrl_decod_saida.
module ctrl_multiciclo
  import ctrl_multiciclo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] estado
);

  estado_t st_q, st_d;
  ctrl_t   ctrl;

  logic is_mem, is_jr, is_r, is_br;
  logic is_imm, is_j, is_jal;

  assign is_mem = (opcode == OP_LW) || (opcode == OP_SW);
  assign is_r   = (opcode == OP_RTYPE);
  assign is_jr  = is_r && (funct == FUNCT_JR);
  assign is_br  = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign is_imm = (opcode == OP_ADDI) || is_logic_imm(opcode);
  assign is_j   = (opcode == OP_J);
  assign is_jal = (opcode == OP_JAL);

  always_ff @(posedge clk) begin
    if (rst) st_q <= S_FETCH;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = S_FETCH;
    unique case (st_q)
      S_FETCH:  st_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          is_mem:         st_d = S_MEMADR;
          is_jr:          st_d = S_JR;
          is_r && !is_jr: st_d = S_EXEC;
          is_br:          st_d = S_BRANCH;
          is_imm:         st_d = S_IEXEC;
          is_j:           st_d = S_JUMP;
          is_jal:         st_d = S_JAL;
          default:        st_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        unique case (1'b1)
          opcode == OP_LW: st_d = S_MEMRD;
          opcode == OP_SW: st_d = S_MEMWR;
          default:         st_d = S_FETCH;
        endcase
      end
      S_MEMRD:  st_d = S_MEMWB;
      S_EXEC:   st_d = S_ALUWB;
      S_IEXEC:  st_d = S_IWB;
      default:  st_d = S_FETCH;
    endcase
  end

  ctrl_decod_saida u_decod (
    .rst    (rst),
    .estado (st_q),
    .opcode (opcode),
    .ctrl   (ctrl)
  );

  assign PCWrite       = ctrl.pcwrite;
  assign PCWriteCond   = ctrl.pcwritecond;
  assign PCWriteCondNe = ctrl.pcwritecondne;
  assign IorD          = ctrl.iord;
  assign MemRead       = ctrl.memread;
  assign MemWrite      = ctrl.memwrite;
  assign IRWrite       = ctrl.irwrite;
  assign RegWrite      = ctrl.regwrite;
  assign RegDst        = ctrl.regdst;
  assign MemtoReg      = ctrl.memtoreg;
  assign ALUSrcA       = ctrl.alusrca;
  assign ALUSrcB       = ctrl.alusrcb;
  assign ExtOp         = ctrl.extop;
  assign ALUOp         = ctrl.aluop;
  assign PCSource      = ctrl.pcsource;
  assign instr_done    = ctrl.instr_done;
  assign illegal_op    = ctrl.illegal_op;
  assign estado        = st_q;

endmodule
